// File: rtl/pokey_div_pkg.sv
// rtl/pokey_div_pkg.sv - shared defaults and helpers for the enable divider bank
package pokey_div_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;

    // div_sel needs at least one bit even for a single-channel bank
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic logic tick_mux(input logic casc, input logic prev_en, input logic base);
        return casc ? prev_en : base;
    endfunction

endpackage

// File: rtl/enable_divider_channel.sv
// rtl/enable_divider_channel.sv - one divider slice: counter, pulse, toggle, active/shadow divisor
module enable_divider_channel #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 0,
    parameter int RESETCOUNT  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             tick,
    input  logic             syncreset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             enable_out,
    output logic             sq_out
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESETCOUNT);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] shadow_div;
    logic             pulse_reg;
    logic             sq_reg;

    assign enable_out = pulse_reg & tick;
    assign sq_out     = sq_reg;

    // syncreset is applied after the tick update so its count overrides wrap/increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            pulse_reg  <= 1'b0;
            sq_reg     <= 1'b0;
            active_div <= DEF_DIV;
            shadow_div <= DEF_DIV;
        end else begin
            if (wr_en) begin
                shadow_div <= wr_data;
            end
            if (ce) begin
                if (tick) begin
                    if (count == active_div) begin
                        count      <= '0;
                        pulse_reg  <= 1'b1;
                        sq_reg     <= ~sq_reg;
                        active_div <= shadow_div;
                    end else begin
                        count      <= count + 1'b1;
                        pulse_reg  <= 1'b0;
                    end
                end
                if (syncreset) begin
                    count      <= RST_CNT;
                    active_div <= shadow_div;
                end
            end
        end
    end

endmodule

// File: rtl/multi_enable_divider.sv
// rtl/multi_enable_divider.sv - bank of runtime-divisor enable dividers with optional cascading
module multi_enable_divider
    import pokey_div_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = 0,
    parameter int RESETCOUNT  = 0,
    localparam int SEL_W      = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic                enable_in,
    input  logic [CHANNELS-1:0] syncreset,
    input  logic [CHANNELS-1:0] cascade,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_data,
    output logic [CHANNELS-1:0] enable_out,
    output logic [CHANNELS-1:0] sq_out
);

    logic unused_cascade0;
    assign unused_cascade0 = cascade[0];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic tick;
        logic ch_en;
        logic ch_sq;
        logic wr_en;

        // the chain is wired through per-channel nets so the tick path stays purely combinational
        if (i == 0) begin : g_base
            assign tick = enable_in;
        end else begin : g_chain
            assign tick = tick_mux(cascade[i], g_ch[i-1].ch_en, enable_in);
        end

        assign wr_en = div_wr && (div_sel == SEL_W'(i));

        enable_divider_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV),
            .RESETCOUNT  (RESETCOUNT)
        ) u_channel (
            .clk        (clk),
            .reset_n    (reset_n),
            .ce         (ce),
            .tick       (tick),
            .syncreset  (syncreset[i]),
            .wr_en      (wr_en),
            .wr_data    (div_data),
            .enable_out (ch_en),
            .sq_out     (ch_sq)
        );

        assign enable_out[i] = ch_en;
        assign sq_out[i]     = ch_sq;
    end

endmodule

// File: tb/tb_multi_enable_divider.sv
// tb/tb_multi_enable_divider.sv - scoreboard bench for multi_enable_divider
module tb_multi_enable_divider;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       enable_in = 1'b0;
    logic [3:0] syncreset = '0;
    logic [3:0] cascade = '0;
    logic       div_wr = 1'b0;
    logic [1:0] div_sel = '0;
    logic [7:0] div_data = '0;
    logic [3:0] enable_out;
    logic [3:0] sq_out;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    logic [7:0] m_cnt[4];
    logic [7:0] m_act[4];
    logic [7:0] m_shd[4];
    logic [3:0] m_pulse;
    logic [3:0] m_sq;

    multi_enable_divider #(
        .CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(0), .RESETCOUNT(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .enable_in(enable_in),
        .syncreset(syncreset), .cascade(cascade), .div_wr(div_wr),
        .div_sel(div_sel), .div_data(div_data),
        .enable_out(enable_out), .sq_out(sq_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 8'd0;
            m_act[i] = 8'd0;
            m_shd[i] = 8'd0;
        end
        m_pulse = '0;
        m_sq = '0;
    endtask

    function automatic logic [3:0] model_en(input logic [3:0] pulse);
        logic [3:0] en;
        en[0] = pulse[0] & enable_in;
        for (int i = 1; i < 4; i++)
            en[i] = pulse[i] & (cascade[i] ? en[i-1] : enable_in);
        return en;
    endfunction

    // advances the model across one clk edge using the currently driven inputs
    task automatic model_edge(output logic [7:0] expv);
        logic [3:0] en_pre;
        logic       t;
        en_pre = model_en(m_pulse);
        for (int i = 0; i < 4; i++) begin
            t = (i == 0) ? enable_in : (cascade[i] ? en_pre[i-1] : enable_in);
            if (ce) begin
                if (t) begin
                    if (m_cnt[i] == m_act[i]) begin
                        m_cnt[i] = 8'd0;
                        m_pulse[i] = 1'b1;
                        m_sq[i] = ~m_sq[i];
                        m_act[i] = m_shd[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] + 8'd1;
                        m_pulse[i] = 1'b0;
                    end
                end
                if (syncreset[i]) begin
                    m_cnt[i] = 8'd0;
                    m_act[i] = m_shd[i];
                end
            end
            if (div_wr && (int'(div_sel) == i))
                m_shd[i] = div_data;
        end
        expv = {m_sq, model_en(m_pulse)};
    endtask

    task automatic step();
        logic [7:0] e;
        model_edge(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({sq_out, enable_out} !== e) begin
            failures++;
            $display("FAIL scoreboard t=%0t actual sq/en=%h required=%h", $time, {sq_out, enable_out}, e);
        end
    endtask

    task automatic write_div(input logic [1:0] sel, input logic [7:0] data);
        div_wr = 1'b1; div_sel = sel; div_data = data;
        step();
        div_wr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (enable_out !== 4'h0) begin
            failures++; $display("FAIL reset_en actual=%h required=0", enable_out);
        end
        checks++;
        if (sq_out !== 4'h0) begin
            failures++; $display("FAIL reset_sq actual=%h required=0", sq_out);
        end
        @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        ce = 1'b1;
    endtask

    task automatic test_div3();
        int pulses = 0;
        int toggles = 0;
        logic prev_sq;
        enable_in = 1'b0;
        write_div(2'd0, 8'd3);
        enable_in = 1'b1;
        prev_sq = sq_out[0];
        for (int k = 0; k < 16; k++) begin
            step();
            pulses += int'(enable_out[0]);
            if (sq_out[0] != prev_sq) toggles++;
            prev_sq = sq_out[0];
        end
        checks++;
        if (pulses != 4) begin
            failures++; $display("FAIL div3_pulses actual=%0d required=4", pulses);
        end
        checks++;
        if (toggles != 4) begin
            failures++; $display("FAIL div3_toggles actual=%0d required=4", toggles);
        end
    endtask

    task automatic test_half_rate();
        int first = -1;
        int pulses = 0;
        int last = -1;
        logic gap_bad = 1'b0;
        enable_in = 1'b0;
        syncreset = 4'b0001;
        step();
        syncreset = '0;
        for (int k = 0; k < 32; k++) begin
            enable_in = (k % 2 == 0);
            step();
            if (enable_out[0]) begin
                if (last >= 0 && k - last != 8) gap_bad = 1'b1;
                if (first < 0) first = k;
                if (!enable_in) gap_bad = 1'b1;
                last = k;
                pulses++;
            end
        end
        checks++;
        if (pulses != 4 || gap_bad || first != 6) begin
            failures++;
            $display("FAIL half_rate actual pulses=%0d first=%0d gap_bad=%0b required 4/6/0", pulses, first, gap_bad);
        end
    endtask

    task automatic test_midwrite();
        logic [15:0] mask = '0;
        enable_in = 1'b0;
        syncreset = 4'b0001;
        step();
        syncreset = '0;
        enable_in = 1'b1;
        step();
        for (int k = 0; k < 14; k++) begin
            div_wr = (k == 0 || k == 6);
            div_sel = 2'd0;
            div_data = (k == 0) ? 8'd1 : 8'd3;
            step();
            mask[k] = enable_out[0];
        end
        div_wr = 1'b0;
        checks++;
        if (mask !== 16'h1154) begin
            failures++; $display("FAIL midwrite_mask actual=%h required=1154", mask);
        end
    endtask

    task automatic test_cascade();
        int p1 = 0;
        int p2 = 0;
        logic bad = 1'b0;
        enable_in = 1'b0;
        write_div(2'd0, 8'd3);
        write_div(2'd1, 8'd1);
        syncreset = 4'b1111;
        step();
        syncreset = '0;
        cascade = 4'b0010;
        enable_in = 1'b1;
        for (int k = 0; k < 24; k++) begin
            step();
            if (enable_out[1]) begin
                p1++;
                if (!enable_out[0]) bad = 1'b1;
            end
            p2 += int'(enable_out[2]);
        end
        checks++;
        if (p1 != 3 || bad) begin
            failures++; $display("FAIL cascade_ch1 actual pulses=%0d misaligned=%0b required 3/0", p1, bad);
        end
        checks++;
        if (p2 != 24) begin
            failures++; $display("FAIL cascade_ch2 actual=%0d required=24", p2);
        end
        cascade = '0;
    endtask

    task automatic test_syncreset();
        int first = -1;
        enable_in = 1'b0;
        write_div(2'd2, 8'd5);
        syncreset = 4'b0100;
        step();
        syncreset = '0;
        enable_in = 1'b1;
        step();
        step();
        for (int k = 0; k < 10; k++) begin
            syncreset = (k == 0) ? 4'b0100 : 4'b0000;
            step();
            if (enable_out[2] && first < 0) first = k;
        end
        syncreset = '0;
        checks++;
        if (first != 6) begin
            failures++; $display("FAIL syncreset_first actual=%0d required=6", first);
        end
    endtask

    task automatic test_ce_freeze();
        logic [7:0] snap;
        logic bad = 1'b0;
        enable_in = 1'b1;
        step();
        step();
        snap = {sq_out, enable_out};
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            div_wr = (k == 2); div_sel = 2'd3; div_data = 8'd2;
            step();
            if ({sq_out, enable_out} !== snap) bad = 1'b1;
        end
        div_wr = 1'b0;
        checks++;
        if (bad) begin
            failures++; $display("FAIL ce_freeze actual changed required=%h", snap);
        end
        ce = 1'b1;
        for (int k = 0; k < 10; k++) step();
    endtask

    task automatic test_reset_mid();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (enable_out !== 4'h0 || sq_out !== 4'h0) begin
            failures++; $display("FAIL async_reset actual en=%h sq=%h required 0/0", enable_out, sq_out);
        end
        model_reset();
        #1;
        reset_n = 1'b1;
        enable_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (enable_out !== 4'hf) begin
                failures++; $display("FAIL reset_default_div actual=%h required=f", enable_out);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_div3();
        test_half_rate();
        test_midwrite();
        test_cascade();
        test_syncreset();
        test_ce_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
